// File: rtl/display_pkg.sv
// Shared constants, state encoding and hex-to-segment table for the 7-segment scan controller.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam logic [3:0]  AN_OFF     = 4'hF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // {g,f,e,d,c,b,a}, active low, indexed by nibble value
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex to active-low 7-segment decode.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit common-anode 7-segment scan controller with double-buffered load and blanking.
// Optional leading-zero blanking is enabled by defining DISPLAY_LZ_BLANK_EN.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic [15:0] load_data,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [3:0]  digit_en,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int unsigned CntMax = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] DigitLast = CntW'(DIGIT_CYCLES - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     shadow_q, shadow_d;
  logic [15:0]     pending_q, pending_d;
  logic            full_q, full_d;
  logic            ready_q;
  logic            tick_q;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;

  logic            boundary, boundary_d, transfer;
  logic [6:0]      dec_seg;
  logic [3:0]      lz;

  hex_to_seg7 u_dec (
    .hex (shadow_q[{idx_q, 2'b00} +: 4]),
    .seg (dec_seg)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == BlankLast) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DigitLast) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
        end
      end
    endcase
  end

  assign boundary   = (state_q == ST_DRIVE) && (cnt_q == DigitLast) && (idx_q == 2'd3);
  // frame_tick is registered, so predict the boundary one cycle ahead
  assign boundary_d = (state_d == ST_DRIVE) && (cnt_d == DigitLast) && (idx_d == 2'd3);
  assign transfer   = load_valid && ready_q;

  always_comb begin
    full_d    = full_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    if (boundary && full_q) begin
      shadow_d = pending_q;
      full_d   = 1'b0;
    end else if (transfer) begin
      pending_d = load_data;
      full_d    = 1'b1;
    end
  end

`ifdef DISPLAY_LZ_BLANK_EN
  assign lz = {shadow_q[15:12] == 4'h0, shadow_q[15:8] == 8'h00, shadow_q[15:4] == 12'h000, 1'b0};
`else
  assign lz = 4'b0000;
`endif

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = AN_OFF;
    if (state_q == ST_DRIVE) begin
      seg_d = dec_seg;
      if (digit_en[idx_q] && !lz[idx_q]) begin
        an_d = ~(4'b0001 << idx_q);
      end
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_BLANK;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      shadow_q  <= 16'h0000;
      pending_q <= 16'h0000;
      full_q    <= 1'b0;
      ready_q   <= 1'b0;
      tick_q    <= 1'b0;
      seg_q     <= SEG_BLANK;
      an_q      <= AN_OFF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      full_q    <= full_d;
      ready_q   <= ~full_d;
      tick_q    <= boundary_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign load_ready = ready_q;
  assign frame_tick = tick_q;
  assign seg        = seg_q;
  assign an         = an_q;

endmodule
